axi4_lite_read_master_pipelined: RTL and testbench
==================================================

// Module: axi4_lite_read_master_pipelined
// PURPOSE
//  AXI4-Lite read master with up to MAX_OUTSTANDING reads in flight, for SoC fetch/load paths.
//  Reads enter through a valid/ready request port and drive the AR channel.
//  R beats are returned in order through a registered valid/ready response port, with RRESP
//  decode. A watchdog flags a slave that stops responding.
// PARAMETERS
//  ADDR_WIDTH       32    AR address width
//  DATA_WIDTH       32    R data width
//  MAX_OUTSTANDING  4     max accepted-but-unanswered reads; power of two, >=1
//  TIMEOUT_CYCLES   1024  idle cycles with reads pending before timeout; 0 disables watchdog
// PORTS
//  clk            in   1           clock, all logic on rising edge
//  rst_n          in   1           asynchronous reset, active-low
//  req_valid      in   1           read request valid
//  req_ready      out  1           request accepted when req_valid&&req_ready
//  req_addr       in   ADDR_WIDTH  read address
//  rsp_valid      out  1           response valid
//  rsp_ready      in   1           consumer accepts response
//  rsp_data       out  DATA_WIDTH  read data
//  rsp_err        out  1           RRESP[1] of the beat (SLVERR/DECERR)
//  busy           out  1           outstanding count != 0 or rsp_valid
//  timeout        out  1           sticky watchdog flag, cleared only by reset
//  M_AXI_ARADDR   out  ADDR_WIDTH  read address
//  M_AXI_ARPROT   out  3           tied 3'b000
//  M_AXI_ARVALID  out  1           address valid
//  M_AXI_ARREADY  in   1           slave accepts address
//  M_AXI_RDATA    in   DATA_WIDTH  read data
//  M_AXI_RRESP    in   2           read response
//  M_AXI_RVALID   in   1           read data valid
//  M_AXI_RREADY   out  1           master accepts read data
// BEHAVIOUR
//  Reset: ARVALID=0, ARADDR=0, rsp_valid=0, rsp_data=0, rsp_err=0, timeout=0, count=0, busy=0.
//   Reset mid-transfer drops all in-flight reads; the slave must be reset in the same domain.
//  Outstanding count (0..MAX_OUTSTANDING):
//   +1 on request handshake; -1 on R handshake (RVALID&&RREADY); both in one cycle -> unchanged.
//  req_ready = (count < MAX_OUTSTANDING) && (!ARVALID || ARREADY).
//   Combinational on ARREADY, no dependence on req_valid.
//  AR channel:
//   Request handshake in cycle N loads ARADDR and sets ARVALID at N+1.
//   ARVALID/ARADDR held stable until ARREADY. ARVALID clears after handshake unless a new
//   request is accepted in the same cycle; then back-to-back ARs, one per cycle.
//  R channel: M_AXI_RREADY = (count != 0) && (!rsp_valid || rsp_ready).
//   R beat in cycle M -> rsp_valid, rsp_data, rsp_err registered at M+1.
//   rsp_valid stays high with data stable until rsp_ready. Responses leave in AR issue order.
//   Full throughput: one R beat per cycle while rsp_ready=1.
//   RVALID with count==0 is a protocol error: RREADY stays 0, beat is never accepted.
//  Watchdog:
//   Counter clears on any R handshake and while count==0.
//   Increments each cycle with count!=0 and no R handshake.
//   Reaching TIMEOUT_CYCLES sets timeout (sticky). Watchdog does not abort or alter traffic.
//  Arithmetic: count is $clog2(MAX_OUTSTANDING+1) bits and never wraps. Watchdog is
//   $clog2(TIMEOUT_CYCLES+1) bits and saturates.
//  Boundaries:
//   count==MAX: req_ready=0 even with ARREADY=1. Freed the cycle after an R handshake.
//   rsp_valid held, rsp_ready=0: RREADY=0, slave back-pressured, count frozen.
// STRUCTURE
//  axi4_lite_pkg: axi_resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11),
//   AXI_PROT_DEFAULT=3'b000. Shared with the write master and slaves.
//  No sub-module. AR register, count, response register and watchdog are small inline processes.
// TESTING
//  1 Single read addr 0x100, ARREADY=1, RVALID 2 cycles later with 0xDEADBEEF/OKAY
//    -> ARVALID 1 cycle; rsp_data=0xDEADBEEF, rsp_err=0; busy low after rsp handshake.
//  2 Burst of 6 requests, ARREADY=1, slave delays all R -> exactly 4 ARs issued,
//    req_ready=0 at count 4; 5th issued the cycle after first R handshake.
//    Data returns in address order.
//  3 ARREADY=0 for 5 cycles on addr 0x2000 -> ARVALID/ARADDR stable throughout; req_ready=0;
//    single AR handshake.
//  4 RRESP=SLVERR, then DECERR, then OKAY -> rsp_err 1,1,0. rsp_ready=0 for 3 cycles holds
//    rsp_data stable and RREADY=0.
//  5 TIMEOUT_CYCLES=16, one read, RVALID never -> timeout rises after 16 cycles, stays high;
//    late R beat still delivered.
//  6 rst_n low with 3 reads in flight and rsp_valid=1 -> all outputs at reset values
//    immediately. Post-reset read completes normally.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: AXI4-Lite response encodings and protection default shared by masters and slaves.
package axi4_lite_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
  function automatic logic resp_is_err(input axi_resp_t r);
    return (r == SLVERR) || (r == DECERR);
  endfunction
endpackage

// File: rtl/axi4_lite_read_master_pipelined.sv
// axi4_lite_read_master_pipelined: AXI4-Lite read master with up to MAX_OUTSTANDING reads in flight,
// in-order registered responses and a sticky no-response watchdog.
module axi4_lite_read_master_pipelined
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);
  localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);
  localparam bit WD_EN = TIMEOUT_CYCLES != 0;
  logic [CW-1:0]         count_q, count_d;
  logic                  ar_valid_q, ar_valid_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [WW-1:0]         wd_q, wd_d;
  logic                  timeout_q, timeout_d;
  logic                  req_hs, r_hs;
  assign req_ready    = (count_q < MAX_C) && (!ar_valid_q || M_AXI_ARREADY);
  assign M_AXI_RREADY = (count_q != '0) && (!rsp_valid_q || rsp_ready);
  assign req_hs       = req_valid && req_ready;
  assign r_hs         = M_AXI_RVALID && M_AXI_RREADY;
  // count covers accepted requests whose R beat has not yet been taken, issued on AR or not
  always_comb begin
    count_d     = count_q + CW'(req_hs) - CW'(r_hs);
    ar_valid_d  = req_hs ? 1'b1 : (M_AXI_ARREADY ? 1'b0 : ar_valid_q);
    ar_addr_d   = req_hs ? req_addr : ar_addr_q;
    rsp_valid_d = r_hs ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
    rsp_data_d  = r_hs ? M_AXI_RDATA : rsp_data_q;
    rsp_err_d   = r_hs ? resp_is_err(axi_resp_t'(M_AXI_RRESP)) : rsp_err_q;
    wd_d        = (r_hs || count_q == '0) ? '0 : (wd_q == WD_MAX ? wd_q : wd_q + WW'(1));
    timeout_d   = timeout_q || (WD_EN && wd_d == WD_MAX);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      ar_valid_q  <= 1'b0;
      ar_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      ar_valid_q  <= ar_valid_d;
      ar_addr_q   <= ar_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
    end
  end
  assign M_AXI_ARVALID = ar_valid_q;
  assign M_AXI_ARADDR  = ar_addr_q;
  assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign busy          = (count_q != '0) || rsp_valid_q;
  assign timeout       = timeout_q;
endmodule

// File: tb/tb_axi4_lite_read_master_pipelined.sv
// tb_axi4_lite_read_master_pipelined: scoreboard bench with an in-order AXI4-Lite slave model.
module tb_axi4_lite_read_master_pipelined;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err, busy, timeout;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b1;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic [31:0] a; logic [31:0] d; logic [1:0] r;} beat_t;
  typedef struct {logic [31:0] d; logic e;} exp_t;
  beat_t slv_q[$], rq[$];
  exp_t  exp_q[$];
  logic  r_ok = 1'b0;
  int    ar_cnt = 0, arv_cyc = 0, first_r = -1, last_hs = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  axi4_lite_read_master_pipelined #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .timeout(timeout),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask
  task automatic fail(input string n);
    total++;
    bad++;
    $display("FAIL %s act=no_event exp=event", n);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r, input logic e);
    int n = 0;
    beat_t b;
    exp_t x;
    req_valid = 1'b1;
    req_addr  = a;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 100);
    if (!req_ready) fail("req_wait");
    else begin
      b.a = a; b.d = d; b.r = r;
      x.d = d; x.e = e;
      slv_q.push_back(b);
      exp_q.push_back(x);
      last_hs = cyc;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle(input string n);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((exp_q.size() != 0 || busy || rsp_valid) && k < 300);
    if (exp_q.size() != 0 || busy) fail(n);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rsp(input string n);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid && k < 50);
    if (!rsp_valid) fail(n);
    @(posedge clk);
    #1;
  endtask
  // slave: accepts AR when arready, returns beats in AR order while r_ok
  initial begin
    logic ar_hs, r_hs;
    logic [31:0] ar_a;
    beat_t b;
    forever begin
      @(negedge clk);
      ar_hs = rst_n && arvalid && arready;
      r_hs  = rst_n && rvalid && rready;
      ar_a  = araddr;
      if (arvalid) arv_cyc++;
      if (r_hs && first_r < 0) first_r = cyc;
      @(posedge clk);
      #2;
      if (!rst_n) begin
        rq.delete();
        rvalid = 1'b0;
      end else begin
        if (ar_hs) begin
          if (slv_q.size() == 0) fail("ar_unexpected");
          else begin
            b = slv_q.pop_front();
            chk("araddr", ar_a, b.a);
            rq.push_back(b);
            ar_cnt++;
          end
        end
        if (r_hs) b = rq.pop_front();
        if (!(rvalid && !r_hs)) rvalid = r_ok && rq.size() > 0;
        if (rvalid) begin
          rdata = rq[0].d;
          rresp = rq[0].r;
        end
      end
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) fail("rsp_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e.d);
          chk("rsp_err", rsp_err, e.e);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench did not finish");
  end
  initial begin
    int base, arv0, c5, n;
    logic [31:0] t2d [6] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002,
                             32'hA000_0003, 32'hA000_0004, 32'hA000_0005};
    #12;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arprot", arprot, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rready", rready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    chk("idle_req_ready", req_ready, 1);
    // single read, slave answers two cycles later
    r_ok = 1'b0;
    arv0 = arv_cyc;
    send(32'h100, 32'hDEAD_BEEF, 2'b00, 1'b0);
    req_valid = 1'b0;
    tick(2);
    r_ok = 1'b1;
    wait_idle("t1_idle");
    chk("t1_arvalid_cycles", arv_cyc - arv0, 1);
    chk("t1_busy", busy, 0);
    // six requests against a stalled R channel: only four may be in flight
    r_ok = 1'b0;
    first_r = -1;
    base = ar_cnt;
    c5 = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(32'h1000 + 32'(i * 4), t2d[i], 2'b00, 1'b0);
          if (i == 4) c5 = last_hs;
        end
        req_valid = 1'b0;
      end
      begin
        tick(8);
        @(negedge clk);
        chk("t2_ar_issued", ar_cnt - base, 4);
        chk("t2_req_ready_full", req_ready, 0);
        chk("t2_busy", busy, 1);
        @(posedge clk);
        #1;
        r_ok = 1'b1;
      end
    join
    wait_idle("t2_idle");
    chk("t2_fifth_after_r", c5 - first_r, 1);
    chk("t2_ar_total", ar_cnt - base, 6);
    // AR back-pressure holds address stable
    arready = 1'b0;
    base = ar_cnt;
    send(32'h2000, 32'h2222_3333, 2'b00, 1'b0);
    req_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_arvalid", arvalid, 1);
      chk("t3_araddr", araddr, 32'h2000);
      chk("t3_req_ready", req_ready, 0);
      @(posedge clk);
      #1;
    end
    arready = 1'b1;
    wait_idle("t3_idle");
    chk("t3_ar_hs", ar_cnt - base, 1);
    // RRESP decode and response back-pressure
    rsp_ready = 1'b0;
    send(32'h3000, 32'h5100_0001, 2'b10, 1'b1);
    send(32'h3004, 32'h5200_0002, 2'b11, 1'b1);
    send(32'h3008, 32'h5300_0003, 2'b00, 1'b0);
    req_valid = 1'b0;
    wait_rsp("t4_rsp");
    repeat (3) begin
      @(negedge clk);
      chk("t4_hold_data", rsp_data, 32'h5100_0001);
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_rready", rready, 0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    wait_idle("t4_idle");
    // watchdog with a silent slave
    chk("t5_timeout_pre", timeout, 0);
    r_ok = 1'b0;
    send(32'h4000, 32'h7777_0004, 2'b00, 1'b0);
    req_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (timeout) break;
      n++;
      @(posedge clk);
      #1;
    end
    chk("t5_timeout_cycles", n, 16);
    tick(3);
    chk("t5_timeout_sticky", timeout, 1);
    r_ok = 1'b1;
    wait_idle("t5_idle");
    chk("t5_timeout_after_r", timeout, 1);
    // asynchronous reset with reads in flight and a held response
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h6000 + 32'(i * 4), 32'h9900_0000 + 32'(i), 2'b10, 1'b1);
    req_valid = 1'b0;
    wait_rsp("t6_rsp");
    tick(1);
    chk("t6_busy_pre", busy, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_arvalid", arvalid, 0);
    chk("t6_araddr", araddr, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_rsp_data", rsp_data, 0);
    chk("t6_rsp_err", rsp_err, 0);
    chk("t6_timeout", timeout, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rready", rready, 0);
    exp_q.delete();
    slv_q.delete();
    tick(2);
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    tick(1);
    chk("t6_req_ready", req_ready, 1);
    send(32'h5000, 32'hC0DE_0005, 2'b01, 1'b0);
    req_valid = 1'b0;
    wait_idle("t6_idle");
    chk("t6_busy_post", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
